// File: rtl/raifes_gpio_ahb_pkg.sv
// Shared constants for the HASTI GPIO slave: bus widths, register word offsets,
// error FSM states and response codes.
// Optional build macro: RAIFES_GPIO_IRQ_EN (adds IE/IP/POL registers).
package raifes_gpio_ahb_pkg;

   // HASTI bus widths
   localparam int unsigned HADDR_W  = 32;
   localparam int unsigned HDATA_W  = 32;
   localparam int unsigned HSIZE_W  = 3;
   localparam int unsigned HBURST_W = 3;
   localparam int unsigned HPROT_W  = 4;
   localparam int unsigned HTRANS_W = 2;
   localparam int unsigned OFF_W    = 6;   // word offset haddr[7:2]

   // Response codes
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Register word offsets (byte offset >> 2)
   localparam logic [OFF_W-1:0] OFF_DOUT = 6'h00;
   localparam logic [OFF_W-1:0] OFF_DIR  = 6'h01;
   localparam logic [OFF_W-1:0] OFF_DIN  = 6'h02;
   localparam logic [OFF_W-1:0] OFF_SET  = 6'h03;
   localparam logic [OFF_W-1:0] OFF_CLR  = 6'h04;
   localparam logic [OFF_W-1:0] OFF_TGL  = 6'h05;
   localparam logic [OFF_W-1:0] OFF_IE   = 6'h06;
   localparam logic [OFF_W-1:0] OFF_IP   = 6'h07;
   localparam logic [OFF_W-1:0] OFF_POL  = 6'h08;

   // Error response sequencer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } state_t;

   // True when the word offset decodes to an implemented register
   function automatic logic offset_mapped(input logic [OFF_W-1:0] off);
`ifdef RAIFES_GPIO_IRQ_EN
      return (off <= OFF_POL);
`else
      return (off <= OFF_TGL);
`endif
   endfunction

endpackage

// File: rtl/raifes_gpio_ahb_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous pad inputs; resets to 0.
module raifes_gpio_ahb_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two back-to-back sampling stages
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/raifes_gpio_ahb.sv
// AHB-lite (HASTI) GPIO slave: zero-wait pipelined access, atomic SET/CLR/TGL,
// synchronised pad inputs, two-cycle ERROR on unmapped offsets.
// Optional build macro: RAIFES_GPIO_IRQ_EN (edge interrupt with IE/IP/POL and irq port).
module raifes_gpio_ahb
   import raifes_gpio_ahb_pkg::*;
#(
   parameter int unsigned N_GPIO    = 8,
   parameter logic [31:0] BASE_ADDR = 32'hC000_0000
) (
   input  logic                clk,
   input  logic                reset,
   output logic [N_GPIO-1:0]   gpio_d,
   output logic [N_GPIO-1:0]   gpio_en,
   input  logic [N_GPIO-1:0]   gpio_i,
   input  logic [HADDR_W-1:0]  haddr,
   input  logic                hwrite,
   input  logic [HSIZE_W-1:0]  hsize,
   input  logic [HBURST_W-1:0] hburst,
   input  logic                hmastlock,
   input  logic [HPROT_W-1:0]  hprot,
   input  logic [HTRANS_W-1:0] htrans,
   input  logic [HDATA_W-1:0]  hwdata,
   output logic [HDATA_W-1:0]  hrdata,
   output logic                hready,
   output logic                hresp
`ifdef RAIFES_GPIO_IRQ_EN
   ,
   output logic                irq
`endif
);

   state_t             state, state_nxt;
   logic               hready_nxt, hresp_nxt;
   logic [N_GPIO-1:0]  din_s;
   logic [OFF_W-1:0]   addr_off;
   logic               in_window, accept, map_ok;
   logic               dp_valid, dp_write;
   logic [OFF_W-1:0]   dp_off;
   logic [N_GPIO-1:0]  wdat;
   logic               wr;
   logic [N_GPIO-1:0]  dout_nxt, dir_nxt;
   logic [HDATA_W-1:0] rd_val;
   logic               unused_ok;

`ifdef RAIFES_GPIO_IRQ_EN
   logic [N_GPIO-1:0]  ie, ip, pol, din_prev;
   logic [N_GPIO-1:0]  ie_nxt, ip_nxt, pol_nxt, edge_det;
`endif

   raifes_gpio_ahb_sync2 #(.WIDTH(N_GPIO)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gpio_i),
      .q     (din_s)
   );

   assign unused_ok = ^{hsize, hburst, hmastlock, hprot, htrans[0], haddr[1:0], hwdata};

   assign addr_off  = haddr[7:2];
   assign in_window = (haddr[HADDR_W-1:8] == BASE_ADDR[HADDR_W-1:8]);
   assign accept    = hready & htrans[1] & in_window;
   assign map_ok    = offset_mapped(addr_off);
   assign wdat      = hwdata[N_GPIO-1:0];
   assign wr        = dp_valid & dp_write;

   // Error sequencer state and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         hready <= 1'b1;
         hresp  <= HRESP_OKAY;
      end else begin
         state  <= state_nxt;
         hready <= hready_nxt;
         hresp  <= hresp_nxt;
      end
   end

   // Next state: unmapped access starts ERR1/ERR2; ERR2 may accept a new transfer
   always_comb begin
      state_nxt  = state;
      hready_nxt = 1'b1;
      hresp_nxt  = HRESP_OKAY;
      case (state)
         ST_IDLE, ST_ERR2: state_nxt = (accept && !map_ok) ? ST_ERR1 : ST_IDLE;
         ST_ERR1:          state_nxt = ST_ERR2;
         default:          state_nxt = ST_IDLE;
      endcase
      hready_nxt = (state_nxt != ST_ERR1);
      hresp_nxt  = (state_nxt == ST_ERR1 || state_nxt == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   end

   // Capture accepted address phase for the following data phase
   always_ff @(posedge clk) begin
      if (reset) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_off   <= '0;
      end else begin
         dp_valid <= accept & map_ok;
         dp_write <= hwrite;
         dp_off   <= addr_off;
      end
   end

`ifdef RAIFES_GPIO_IRQ_EN
   // Edge of the selected polarity on the synchronised input
   assign edge_det = (pol & din_s & ~din_prev) | (~pol & ~din_s & din_prev);
`endif

   // Register next values from the data-phase write
   always_comb begin
      dout_nxt = gpio_d;
      dir_nxt  = gpio_en;
`ifdef RAIFES_GPIO_IRQ_EN
      ie_nxt   = ie;
      pol_nxt  = pol;
      ip_nxt   = ip;
`endif
      if (wr) begin
         case (dp_off)
            OFF_DOUT: dout_nxt = wdat;
            OFF_DIR:  dir_nxt  = wdat;
            OFF_SET:  dout_nxt = gpio_d | wdat;
            OFF_CLR:  dout_nxt = gpio_d & ~wdat;
            OFF_TGL:  dout_nxt = gpio_d ^ wdat;
`ifdef RAIFES_GPIO_IRQ_EN
            OFF_IE:   ie_nxt   = wdat;
            OFF_IP:   ip_nxt   = ip & ~wdat;
            OFF_POL:  pol_nxt  = wdat;
`endif
            default:  ;
         endcase
      end
`ifdef RAIFES_GPIO_IRQ_EN
      ip_nxt = ip_nxt | edge_det;   // a new edge beats a same-cycle clear
`endif
   end

   // Read mux uses next values so a write followed by a read sees the new data
   always_comb begin
      rd_val = '0;
      case (addr_off)
         OFF_DOUT: rd_val = HDATA_W'(dout_nxt);
         OFF_DIR:  rd_val = HDATA_W'(dir_nxt);
         OFF_DIN:  rd_val = HDATA_W'(din_s);
`ifdef RAIFES_GPIO_IRQ_EN
         OFF_IE:   rd_val = HDATA_W'(ie_nxt);
         OFF_IP:   rd_val = HDATA_W'(ip_nxt);
         OFF_POL:  rd_val = HDATA_W'(pol_nxt);
`endif
         default:  rd_val = '0;
      endcase
   end

   // Register file and read data
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_d  <= '0;
         gpio_en <= '0;
         hrdata  <= '0;
      end else begin
         gpio_d  <= dout_nxt;
         gpio_en <= dir_nxt;
         hrdata  <= (accept && map_ok && !hwrite) ? rd_val : '0;
      end
   end

`ifdef RAIFES_GPIO_IRQ_EN
   // Interrupt enable/pending/polarity, edge history and level interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         ie       <= '0;
         ip       <= '0;
         pol      <= '0;
         din_prev <= '0;
         irq      <= 1'b0;
      end else begin
         ie       <= ie_nxt;
         ip       <= ip_nxt;
         pol      <= pol_nxt;
         din_prev <= din_s;
         irq      <= |(ip & ie);
      end
   end
`endif

endmodule
